// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and helpers for the multiply/divide unit
package mdu_pkg;

   localparam int MDU_ITER = 32;

   localparam logic [1:0] MDU_MULT  = 2'd0;
   localparam logic [1:0] MDU_MULTU = 2'd1;
   localparam logic [1:0] MDU_DIV   = 2'd2;
   localparam logic [1:0] MDU_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             dividend_bit,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   // The partial remainder is always below the divisor, so its top bit is never set
   logic           rem_top_unused;

   // Shift in the next dividend bit, trial-subtract, restore when the subtract borrows
   always_comb begin
      rem_top_unused = rem_in[WIDTH];
      shifted        = {rem_in[WIDTH-1:0], dividend_bit};
      diff           = shifted - {1'b0, divisor};
      q_bit          = ~diff[WIDTH];
      rem_out        = q_bit ? diff : shifted;
   end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MIPS MULT/MULTU/DIV/DIVU unit feeding HI/LO; MDU_FAST_MUL_EN selects single-cycle multiply
import mdu_pkg::*;

module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   mdu_state_t       state;
   logic [5:0]       cnt;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH:0]   acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd_b;

   logic             sign_a, sign_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             div_zero;
   logic [WIDTH:0]   step_rem;
   logic             step_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   iter_hi;
   logic [WIDTH-1:0] iter_lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;

   // Sign- or zero-extend to full width; the low 2*WIDTH bits of the product are exact either way
   always_comb begin
      if (op[0])
         fast_prod = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
      else
         fast_prod = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
   end
`endif

   // Operand signs and magnitudes captured at start; unsigned ops never negate
   always_comb begin
      sign_a   = ~op[0] & src_a[WIDTH-1];
      sign_b   = ~op[0] & src_b[WIDTH-1];
      mag_a    = sign_a ? (~src_a + 1'b1) : src_a;
      mag_b    = sign_b ? (~src_b + 1'b1) : src_b;
      div_zero = op[1] & (src_b == '0);
   end

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in       (acc_hi),
      .divisor      (opnd_b),
      .dividend_bit (acc_lo[WIDTH-1]),
      .rem_out      (step_rem),
      .q_bit        (step_q)
   );

   // Next accumulator value for one iteration, plus the sign-corrected result used on the last one
   always_comb begin
      mul_sum = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
      prod    = '0;
      if (is_div) begin
         iter_hi = step_rem;
         iter_lo = {acc_lo[WIDTH-2:0], step_q};
         res_lo  = neg_q ? (~iter_lo + 1'b1) : iter_lo;
         res_hi  = neg_r ? (~iter_hi[WIDTH-1:0] + 1'b1) : iter_hi[WIDTH-1:0];
      end else begin
         iter_hi          = {1'b0, mul_sum[WIDTH:1]};
         iter_lo          = {mul_sum[0], acc_lo[WIDTH-1:1]};
         prod             = {iter_hi[WIDTH-1:0], iter_lo};
         prod             = neg_q ? (~prod + 1'b1) : prod;
         {res_hi, res_lo} = prod;
      end
   end

   // Stall the issuing instruction in its own start cycle and throughout CALC
   assign stall = ~rst & (((state == IDLE) & start & ~cancel) | (state == CALC));
   assign busy  = (state != IDLE);

   // Control FSM, iteration datapath and registered HI/LO results
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd_b <= '0;
         done   <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
      end else if (cancel) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (div_zero) begin
                     hi_out <= src_a;
                     lo_out <= '1;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
`ifdef MDU_FAST_MUL_EN
                  else if (~op[1]) begin
                     {hi_out, lo_out} <= fast_prod;
                     done             <= 1'b1;
                     state            <= DONE;
                  end
`endif
                  else begin
                     acc_hi <= '0;
                     acc_lo <= mag_a;
                     opnd_b <= mag_b;
                     is_div <= op[1];
                     neg_q  <= sign_a ^ sign_b;
                     neg_r  <= sign_a;
                     cnt    <= '0;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               acc_hi <= iter_hi;
               acc_lo <= iter_lo;
               cnt    <= cnt + 6'd1;
               if (cnt == 6'(MDU_ITER - 1)) begin
                  hi_out <= res_hi;
                  lo_out <= res_lo;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        cancel;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int checks = 0;
   int errors = 0;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .cancel (cancel),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a rising edge; returns at the same point of the first IDLE cycle
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int lat);
      int cyc;
      int stall_cnt;
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      #1;
      cyc       = 0;
      stall_cnt = 0;
      while (!done && cyc < 100) begin
         if (stall) stall_cnt++;
         tick;
         start = 1'b0;
         #1;
         cyc++;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
      chk({tag, "_stallcyc"}, 64'(stall_cnt), 64'(lat));
      chk({tag, "_stall_done"}, 64'(stall), 64'd0);
      chk({tag, "_hi"}, 64'(hi_out), 64'(eh));
      chk({tag, "_lo"}, 64'(lo_out), 64'(el));
      tick;
      chk({tag, "_done1"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_hold"}, {hi_out, lo_out}, {eh, el});
   endtask

   initial begin
      logic seen;
      rst    = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      op     = MDU_MULT;
      src_a  = '0;
      src_b  = '0;
      tick;
      tick;
      start = 1'b1;
      #1;
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_state", {hi_out, lo_out}, 64'd0);
      chk("rst_flags", {62'd0, done, busy}, 64'd0);
      start = 1'b0;
      tick;
      rst = 1'b0;
      tick;

      run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
      run_op("mult_neg",  MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
      run_op("div_neg",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
      run_op("divu",      MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);
      run_op("div_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT);
      run_op("divu_z",    MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1);
      run_op("div_z",     MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
      run_op("divu_pre",  MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);

      // DIV started in cycle 0, cancel pulsed in cycle 10
      op    = MDU_DIV;
      src_a = 32'hFFFF_FFF9;
      src_b = 32'd2;
      start = 1'b1;
      seen  = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick;
         start = 1'b0;
         if (done) seen = 1'b1;
         if (c == 10) cancel = 1'b1;
      end
      tick;
      cancel = 1'b0;
      if (done) seen = 1'b1;
      chk("cancel_nodone", 64'(seen), 64'd0);
      chk("cancel_busy", 64'(busy), 64'd0);
      chk("cancel_hold", {hi_out, lo_out}, {32'd2, 32'd14});
      run_op("after_cancel", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);

      // start together with cancel in IDLE latches nothing
      op     = MDU_DIVU;
      src_a  = 32'd9;
      src_b  = 32'd0;
      start  = 1'b1;
      cancel = 1'b1;
      #1;
      chk("startcancel_stall", 64'(stall), 64'd0);
      tick;
      start  = 1'b0;
      cancel = 1'b0;
      chk("startcancel_busy", 64'(busy), 64'd0);
      tick;
      chk("startcancel_done", 64'(done), 64'd0);
      chk("startcancel_hold", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      // rst asserted in cycle 5 of a MULTU
      op    = MDU_MULTU;
      src_a = 32'd7;
      src_b = 32'd9;
      start = 1'b1;
      seen  = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         tick;
         start = 1'b0;
         if (c >= 2 && done) seen = 1'b1;
         if (c == 5) rst = 1'b1;
      end
      #1;
      chk("rstmid_stall", 64'(stall), 64'd0);
      tick;
      chk("rstmid_out", {hi_out, lo_out}, 64'd0);
      chk("rstmid_flags", {62'd0, done, busy}, 64'd0);
      chk("rstmid_nodone", 64'(seen), 64'd0);
      rst = 1'b0;
      tick;
      run_op("after_rst", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit for the MIPS EX stage; sits directly upstream of the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU with two 32-bit operands, stalls the pipeline while computing, then presents a 64-bit result as hi/lo with a one-cycle write strobe that drives the HI/LO register write enable.

## Interface
- WIDTH, 32, operand width; the unit is only verified at 32.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- src_a  in  32  multiplicand / dividend (rs)
- src_b  in  32  multiplier / divisor (rt)
- cancel  in  1  pipeline flush; aborts any operation
- stall  out  1  hold the EX stage
- busy  out  1  state != IDLE
- done  out  1  one-cycle result strobe; connects to the HI/LO write enable
- hi_out  out  32  product[63:32] or remainder
- lo_out  out  32  product[31:0] or quotient

## Operation
- States:
  - IDLE: `start & ~cancel` latches the operands and goes to CALC (or to DONE for a fast path).
  - CALC: runs 32 iterations with a 6-bit counter, then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Signed ops (op[0]=0):
  - Operands are converted to magnitudes at start; the signs are recorded.
  - Product sign and quotient sign are sa^sb. Remainder sign is sa.
  - The final negation is applied when entering DONE.
- Multiply: iterative shift-add over the 64-bit accumulator, one multiplier bit per cycle.
- Divide: restoring radix-2, one quotient bit per cycle; the remainder register is 33 bits wide for the subtract.
- Divide by zero (src_b==0, either signedness):
  - Skips CALC and goes IDLE→DONE.
  - lo_out=32'hFFFF_FFFF, hi_out=src_a.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: lo_out=0x8000_0000, hi_out=0. This falls out of the magnitude arithmetic; there is no special case.
- hi_out and lo_out are registered. They update only on entry to DONE and hold until the next DONE.
- start while busy is ignored. The pipeline never issues it because stall is high.
- cancel in any state:
  - The next state is IDLE.
  - No done pulse is produced.
  - hi_out and lo_out keep their previous values.
- cancel together with start in IDLE: cancel wins and nothing is latched.
- rst in any state, including mid-CALC: the next state is IDLE and all registers are cleared.

## Timing
- Reset values: hi_out=0, lo_out=0, done=0, busy=0. stall is forced to 0 while rst is high.
- stall = (IDLE & start & ~cancel) | CALC. It is combinational, so the issuing instruction stalls in its own start cycle.
- stall is low in DONE, so EX advances in the same cycle that done writes HI/LO.
- Latency with start in cycle 0:
  - Iterative op: CALC in cycles 1–32, DONE (done=1) in cycle 33.
  - Divide-by-zero or fast multiply: DONE in cycle 1.
- Back-to-back: a new start is accepted in the cycle after DONE, i.e. the first IDLE cycle.
- done is high for exactly one cycle per accepted, uncancelled operation.

## Configuration
- MDU_FAST_MUL_EN:
  - When defined, MULT/MULTU compute the full 64-bit product with a single registered multiply and go IDLE→DONE, so done arrives in cycle 1.
  - When undefined, multiplies use the 32-cycle iterative path.
- Divide behaviour is identical in both builds.

## Structure
- Shared package mdu_pkg holds:
  - the op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the state encoding (IDLE, CALC, DONE);
  - the iteration count constant MDU_ITER=32.
- One sub-module, mdu_div_step:
  - combinational single restoring-division step;
  - inputs: 33-bit partial remainder, divisor, next dividend bit;
  - outputs: new remainder, quotient bit.
- The top level owns the FSM, counter, sign fixup and the multiply path.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001; done in cycle 33 (cycle 1 with MDU_FAST_MUL_EN); stall high in cycles 0–32.
- MULT −3 × 5 → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- DIV −7 / 2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU 100 / 7 → lo=14, hi=2.
- DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU 5 / 0 → done in cycle 1, lo=0xFFFF_FFFF, hi=5.
- DIVU 100/7 completed first, then DIV started and cancel raised in cycle 10:
  - no done pulse; hi/lo stay 2/14; busy=0 next cycle;
  - a fresh start is accepted the cycle after that.
- rst asserted in cycle 5 of MULTU → all outputs 0 the next cycle; no done pulse.
